// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one 32-bit schedule word per cycle, round keys 0..10 over valid/ready.
// Optional macro AES_KEY_EXP_REG_SBOX_EN registers the S-box output (j=0 word takes two cycles).

module sub_bytes (
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);
    // Forward AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            // Entry x lives at bit offset (255-x)*8, i.e. {~x, 3'b000}.
            assign data_o[gi*8 +: 8] = SBOX[{~data_i[gi*8 +: 8], 3'b000} +: 8];
        end
    endgenerate
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_data
);
    typedef enum logic [1:0] {IDLE, EMIT, GEN} state_t;

    state_t           state_q, state_d;
    logic [3:0][31:0] w_q, w_d;          // w_q[0] is the first word of the round key
    logic [1:0]       j_q, j_d;
    logic [3:0]       round_q, round_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [127:0]     rk_data_q, rk_data_d;
    logic [31:0]      rot_word, sub_word, sub_src, temp, new_word;
    logic             gen_write;

    assign rot_word = {w_q[3][23:0], w_q[3][31:24]};

    sub_bytes u_sub_bytes (
        .data_i (rot_word),
        .data_o (sub_word)
    );

`ifdef AES_KEY_EXP_REG_SBOX_EN
    logic        sub_vld_q, sub_vld_d;
    logic [31:0] sub_q;

    // First j=0 cycle only captures SubWord; the second one writes w0.
    assign sub_vld_d = (state_q == GEN) && (j_q == 2'd0) && !sub_vld_q;
    assign gen_write = (j_q != 2'd0) || sub_vld_q;
    assign sub_src   = sub_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_vld_q <= 1'b0;
            sub_q     <= 32'h0;
        end else begin
            sub_vld_q <= sub_vld_d;
            sub_q     <= sub_word;
        end
    end
`else
    assign gen_write = 1'b1;
    assign sub_src   = sub_word;
`endif

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        j_d       = j_q;
        round_d   = round_q;
        rcon_d    = rcon_q;
        rk_data_d = rk_data_q;
        temp      = (j_q == 2'd0) ? (sub_src ^ {rcon_q, 24'h0}) : w_q[j_q - 2'd1];
        new_word  = w_q[j_q] ^ temp;

        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    w_d[0]    = key_in[127:96];
                    w_d[1]    = key_in[95:64];
                    w_d[2]    = key_in[63:32];
                    w_d[3]    = key_in[31:0];
                    round_d   = 4'd0;
                    rcon_d    = 8'h01;
                    rk_data_d = key_in;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    j_d     = 2'd0;
                    state_d = (round_q == 4'd10) ? IDLE : GEN;
                end
            end
            GEN: begin
                if (gen_write) begin
                    w_d[j_q] = new_word;
                    j_d      = j_q + 2'd1;
                    if (j_q == 2'd3) begin
                        round_d   = round_q + 4'd1;
                        rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                        rk_data_d = {w_q[0], w_q[1], w_q[2], new_word};
                        state_d   = EMIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            w_q       <= '0;
            j_q       <= 2'd0;
            round_q   <= 4'd0;
            rcon_q    <= 8'h01;
            rk_data_q <= 128'h0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            j_q       <= j_d;
            round_q   <= round_d;
            rcon_q    <= rcon_d;
            rk_data_q <= rk_data_d;
        end
    end

    assign key_ready = (state_q == IDLE) && !rst;
    assign rk_valid  = (state_q == EMIT);
    assign rk_round  = round_q;
    assign rk_data   = rk_data_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 and all-zero key schedules, backpressure,
// ignored keys, mid-schedule reset and back-to-back keys.
module tb_aes_key_expand;
`ifdef AES_KEY_EXP_REG_SBOX_EN
    localparam int GAP = 6;
`else
    localparam int GAP = 5;
`endif
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic [127:0] rk;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [3:0]   rk_round;
    logic [127:0] rk_data;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t vecs [22];

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .rk_data   (rk_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the round-10 handshake.
    task automatic run_key(input logic [127:0] key, input int ksel, input bit rnd_ready,
                           input bit spam, input logic [127:0] spam_key, input bit keep,
                           output int t_acc, output int t_last);
        int           r, n;
        bit           stall_prev;
        logic [127:0] held_data;
        logic [3:0]   held_round;
        key_valid = 1'b1;
        key_in    = key;
        n = 0;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("key_accept_wait", 128'(key_ready), 128'd1);
        t_acc = cyc;
        t_last = cyc;
        @(negedge clk);
        key_valid  = spam;
        key_in     = spam_key;
        r          = 0;
        n          = 0;
        stall_prev = 1'b0;
        held_data  = '0;
        held_round = '0;
        while (r <= 10 && n < 2000) begin
            rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("busy_key_ready", 128'(key_ready), 128'd0);
            if (stall_prev) begin
                chk("stall_valid", 128'(rk_valid), 128'd1);
                chk("stall_data", rk_data, held_data);
                chk("stall_round", 128'(rk_round), 128'(held_round));
            end
            stall_prev = 1'b0;
            if (rk_valid) begin
                if (rk_ready) begin
                    chk($sformatf("k%0d_r%0d_data", ksel, r), rk_data, vecs[ksel*11 + r].rk);
                    chk($sformatf("k%0d_r%0d_round", ksel, r), 128'(rk_round),
                        128'(vecs[ksel*11 + r].rnd));
                    if (!rnd_ready)
                        chk($sformatf("k%0d_r%0d_cycle", ksel, r), 128'(cyc),
                            128'(t_acc + 1 + GAP*r));
                    t_last = cyc;
                    r++;
                end else begin
                    stall_prev = 1'b1;
                    held_data  = rk_data;
                    held_round = rk_round;
                end
            end
            @(negedge clk);
            n++;
        end
        chk("schedule_done", 128'(r), 128'd11);
        chk("idle_key_ready", 128'(key_ready), 128'd1);
        chk("idle_rk_valid", 128'(rk_valid), 128'd0);
        if (!keep) key_valid = 1'b0;
    endtask

    initial begin
        int ta, tl, ta2, tl2, n, hs;
        vecs[0]  = '{FIPS_KEY, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{FIPS_KEY, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{FIPS_KEY, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{FIPS_KEY, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{FIPS_KEY, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{FIPS_KEY, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{FIPS_KEY, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{FIPS_KEY, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{FIPS_KEY, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{FIPS_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[11] = '{ZERO_KEY, 4'd0,  128'h00000000000000000000000000000000};
        vecs[12] = '{ZERO_KEY, 4'd1,  128'h62636363626363636263636362636363};
        vecs[13] = '{ZERO_KEY, 4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
        vecs[14] = '{ZERO_KEY, 4'd3,  128'h90973450696ccffaf2f457330b0fac99};
        vecs[15] = '{ZERO_KEY, 4'd4,  128'hee06da7b876a1581759e42b27e91ee2b};
        vecs[16] = '{ZERO_KEY, 4'd5,  128'h7f2e2b88f8443e098dda7cbbf34b9290};
        vecs[17] = '{ZERO_KEY, 4'd6,  128'hec614b851425758c99ff09376ab49ba7};
        vecs[18] = '{ZERO_KEY, 4'd7,  128'h217517873550620bacaf6b3cc61bf09b};
        vecs[19] = '{ZERO_KEY, 4'd8,  128'h0ef903333ba9613897060a04511dfa9f};
        vecs[20] = '{ZERO_KEY, 4'd9,  128'hb1d4d8e28a7db9da1d7bb3de4c664941};
        vecs[21] = '{ZERO_KEY, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_key_ready", 128'(key_ready), 128'd0);
        chk("rst_rk_data", rk_data, 128'd0);
        chk("rst_rk_round", 128'(rk_round), 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_key_ready", 128'(key_ready), 128'd1);
        @(negedge clk);

        // Full schedules with rk_ready tied high
        for (int k = 0; k < 2; k++) begin
            run_key(vecs[k*11].key, k, 1'b0, 1'b0, '0, 1'b0, ta, tl);
            chk($sformatf("k%0d_total_latency", k), 128'(tl - ta), 128'(1 + GAP*10));
            $display("key %0d schedule accepted at %0d, round 10 at %0d", k, ta, tl);
            @(negedge clk);
        end

        // Random backpressure with a competing key pulsed throughout
        run_key(FIPS_KEY, 0, 1'b1, 1'b1, 128'hdeadbeef0123456789abcdeffedcba98, 1'b0, ta, tl);
        $display("backpressure schedule accepted at %0d, round 10 at %0d", ta, tl);
        @(negedge clk);

        // Reset during round-5 generation
        key_valid = 1'b1;
        key_in    = FIPS_KEY;
        rk_ready  = 1'b1;
        n = 0;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        key_valid = 1'b0;
        hs = 0;
        n  = 0;
        while (hs < 5 && n < 200) begin
            if (rk_valid && rk_ready) hs++;
            @(negedge clk);
            n++;
        end
        chk("midrst_reach_r5", 128'(hs), 128'd5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rk_valid", 128'(rk_valid), 128'd0);
        chk("midrst_key_ready", 128'(key_ready), 128'd0);
        chk("midrst_rk_data", rk_data, 128'd0);
        rst = 1'b0;
        #1;
        chk("midrst_release_key_ready", 128'(key_ready), 128'd1);
        run_key(ZERO_KEY, 1, 1'b0, 1'b0, '0, 1'b0, ta, tl);
        $display("post-reset zero key accepted at %0d, round 10 at %0d", ta, tl);
        @(negedge clk);

        // Back-to-back keys: second key held valid from the first acceptance onward
        run_key(FIPS_KEY, 0, 1'b0, 1'b1, ZERO_KEY, 1'b1, ta, tl);
        run_key(ZERO_KEY, 1, 1'b0, 1'b0, '0, 1'b0, ta2, tl2);
        chk("b2b_accept_cycle", 128'(ta2), 128'(tl + 1));
        $display("back-to-back: first done at %0d, second accepted at %0d", tl, ta2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
